fifo_rr_arbiter: RTL and testbench
==================================

# fifo_rr_arbiter

Round-robin write arbiter sharing the 16-entry, 8-bit write port of `fifo_clean` among several producers. Each producer offers bursts over a valid/ready handshake. The arbiter grants one producer at a time and passes its beats combinationally onto the FIFO `write_en`/`data_in` pins, gated by the FIFO `full` flag. Bursts are capped, so no producer can monopolise the buffer.

## Interface
- `NUM_REQ`, default 4: number of producers; legal range 2..8.
- `DATA_W`, default 8: beat width; must match the FIFO `data_in` width.
- `MAX_BURST`, default 4: maximum beats per grant; legal range 1..16.
- `GW`, derived: `$clog2(NUM_REQ)`.
- `CW`, derived: `$clog2(MAX_BURST+1)`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-producer beat valid.
- `req_last`  in  NUM_REQ  per-producer end-of-burst marker, qualified by `req_valid`.
- `req_data`  in  NUM_REQ*DATA_W  producer k occupies bits [k*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ  per-producer beat accept.
- `fifo_full`  in  1  FIFO `full` flag.
- `fifo_write_en`  out  1  drives FIFO `write_en`.
- `fifo_data_in`  out  DATA_W  drives FIFO `data_in`.
- `grant_active`  out  1  high in state BURST.
- `grant_id`  out  GW  index of the current or most recent grantee.
- `beat_cnt`  out  CW  beats accepted in the current burst.

## Operation
- FSM has two states, IDLE and BURST.
- Registered state:
  - `state`
  - `grant_id`
  - `last_grant` (GW bits)
  - `beat_cnt`
- Reset values:
  - `state` = IDLE, `grant_id` = 0, `last_grant` = NUM_REQ-1, `beat_cnt` = 0.
  - Outputs after reset: `req_ready` = 0, `fifo_write_en` = 0, `fifo_data_in` = 0, `grant_active` = 0.
- IDLE:
  - If any `req_valid` bit is set, grant the first set index scanning `last_grant+1, last_grant+2, …` modulo NUM_REQ.
  - Load that index into `grant_id`, clear `beat_cnt`, go to BURST.
  - If no `req_valid` bit is set, stay in IDLE.
  - All `req_ready` bits are 0 in IDLE.
- BURST, with grantee g:
  - `req_ready[g]` = !fifo_full; all other `req_ready` bits are 0.
  - A beat is accepted when `req_valid[g] & req_ready[g]`.
  - On an accepted beat: `fifo_write_en` = 1 and `fifo_data_in` = `req_data[g]`, combinationally in the same cycle; `beat_cnt` increments.
  - When no beat is accepted: `fifo_write_en` = 0 and `fifo_data_in` = 0.
- BURST exits to IDLE, setting `last_grant` = g, on any of:
  - (a) accepted beat with `req_last[g]` = 1;
  - (b) accepted beat that brings `beat_cnt+1` to MAX_BURST;
  - (c) `req_valid[g]` = 0 for one cycle (producer gap releases the grant).
- Backpressure: when `fifo_full` = 1 with `req_valid[g]` = 1, hold the grant with no beat. This is neither a gap nor an exit.
- Simultaneous `req_last` and MAX_BURST on the same beat: a single exit.
- `req_valid`/`req_last` from non-granted producers are ignored. Producers hold `req_data` stable while valid and not ready.
- Reset mid-burst: immediate return to reset values. Any beat in that cycle is dropped (`fifo_write_en` forced 0 asynchronously).
- Arithmetic:
  - Rotation index is computed modulo NUM_REQ, including non-power-of-2 values.
  - `beat_cnt` never exceeds MAX_BURST.

## Timing
- Arbitration latency: first `req_valid` in IDLE gives `req_ready` high on the next cycle.
- One dead IDLE cycle separates consecutive bursts.
- Throughput is one beat per cycle within a burst while `fifo_full` = 0.
- Data path is zero-latency and combinational: `req_data` → `fifo_data_in`, `fifo_full` → `req_ready`.
- `fifo_full` is sampled combinationally each cycle. Because the FIFO updates `full` on the write edge, the cycle after the 16th write already sees `full` = 1, so no overflow occurs.

## Structure
- Shared package `fifo_pkg` holds:
  - the FSM state enum `{IDLE, BURST}`;
  - FIFO constants `FIFO_DEPTH=16` and `FIFO_DW=8`.
- One sub-module, `rr_pick`: combinational rotating-priority encoder.
  - Inputs: `req[NUM_REQ]`, `last[GW]`.
  - Outputs: `idx[GW]`, `any`.
- Top-level instantiation test: `fifo_rr_arbiter` driving `fifo_clean` write port; the FIFO `read_en` is driven by the bench.

## Test plan
- **Reset:** assert `rst` mid-burst (g=2, `beat_cnt`=2) → all outputs 0 within the same cycle; after release, first grant goes to index 0 when all are valid.
- **Rotation:** all 4 valid, single-beat bursts with `req_last`=1 → grant order 0,1,2,3,0; beats spaced 2 cycles apart.
- **Burst cap:** producer 1 streams 0x10..0x19 without `req_last`, MAX_BURST=4 → FIFO receives 0x10–0x13, then another producer's burst, then 0x14–0x17.
- **Gap release:** producer 3 valid 2 cycles, drops 1 cycle, producer 0 waiting → grant moves to 0, and `grant_id` = 3 is recorded in `last_grant`.
- **Full backpressure:** fill the FIFO to 16 entries → `req_ready` = 0 and `fifo_write_en` never asserted while `full` = 1; grant is held and not released.
- **Non-power-of-2:** NUM_REQ=3, only producers 0 and 2 valid → grants alternate 0,2,0,2.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encoding,
// the geometry of the downstream FIFO, and the rotation helper.
package fifo_pkg;

    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_DW    = 8;

    // IDLE: no grant held, arbitration happens here.
    // BURST: one producer owns the FIFO write port.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Wrap a rotation candidate back into 0..n-1. Candidates never reach 2*n,
    // so one conditional subtract covers non-power-of-2 counts as well.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: finds the first set request after `last`,
// wrapping modulo NUM_REQ. Purely combinational.
module rr_pick
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      last,
    output logic [GW-1:0]      idx,
    output logic               any
);

    // Scan from the farthest candidate down to last+1 so the nearest
    // requester after `last` is the final one to overwrite idx.
    always_comb begin
        int          cand;
        logic [GW-1:0] cand_idx;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand     = rr_wrap(int'(last) + i, NUM_REQ);
            cand_idx = GW'(cand);
            if (req[cand_idx]) begin
                idx = cand_idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin write arbiter in front of a FIFO write port. One producer at a
// time owns the port; its beats pass combinationally to write_en/data_in,
// gated by the FIFO full flag. Bursts end on last, on the MAX_BURST cap, or
// when the granted producer drops valid for a cycle.
//
// Handshake: a beat moves when req_valid[g] && req_ready[g] are both high in
// the same cycle; req_ready[g] depends only on state, grant_id and fifo_full,
// never on req_valid, and producers hold data stable until it is accepted.
module fifo_rr_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = FIFO_DW,
    parameter int MAX_BURST = 4,
    parameter int GW        = $clog2(NUM_REQ),
    parameter int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_write_en,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic                      grant_active,
    output logic [GW-1:0]             grant_id,
    output logic [CW-1:0]             beat_cnt
);

    // beat_cnt value at which the next accepted beat reaches the cap
    localparam logic [CW-1:0] CAP_M1 = CW'(MAX_BURST - 1);

    arb_state_t        state;
    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     pick_idx;
    logic              pick_any;
    logic              valid_g;
    logic              last_g;
    logic [DATA_W-1:0] data_g;
    logic              ready_g;
    logic              accept;
    logic              cap_hit;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_pick (
        .req  (req_valid),
        .last (last_grant),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Select the granted producer's valid/last/data lanes.
    always_comb begin
        valid_g = 1'b0;
        last_g  = 1'b0;
        data_g  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == GW'(k)) begin
                valid_g = req_valid[k];
                last_g  = req_last[k];
                data_g  = req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Ready is withheld while reset is high so a beat in the reset cycle is
    // dropped even before the state register has settled.
    assign ready_g = (state == BURST) && !fifo_full && !rst;
    assign accept  = ready_g && valid_g;
    assign cap_hit = (beat_cnt == CAP_M1);

    // Only the grantee ever sees ready.
    always_comb begin
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_ready[k] = ready_g && (grant_id == GW'(k));
        end
    end

    assign fifo_write_en = accept;
    assign fifo_data_in  = accept ? data_g : '0;
    assign grant_active  = (state == BURST);

    // Arbitration FSM: pick in IDLE, stream beats in BURST, release on
    // last / cap / producer gap. Backpressure (full with valid) holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + CW'(1);
                        if (last_g || cap_hit) begin
                            state      <= IDLE;
                            last_grant <= grant_id;
                        end
                    end else if (!valid_g) begin
                        state      <= IDLE;
                        last_grant <= grant_id;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: a 4-producer instance in front of a
// behavioural 16-entry FIFO, plus a 3-producer instance for the
// non-power-of-2 rotation. Expected writes go into queues when stimulus is
// issued; monitors pop and compare on every FIFO write.
module tb_fifo_rr_arbiter;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int MB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- 4-producer DUT ----------------
  logic [3:0]    req_valid, req_last, req_ready;
  logic [4*DW-1:0] req_data;
  logic          fifo_full, fifo_write_en;
  logic [DW-1:0] fifo_data_in;
  logic          grant_active;
  logic [1:0]    grant_id;
  logic [2:0]    beat_cnt;

  fifo_rr_arbiter #(.NUM_REQ(4), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_write_en(fifo_write_en), .fifo_data_in(fifo_data_in),
    .grant_active(grant_active), .grant_id(grant_id), .beat_cnt(beat_cnt)
  );

  // ---------------- 3-producer DUT ----------------
  logic [2:0]    req_valid3, req_last3, req_ready3;
  logic [3*DW-1:0] req_data3;
  logic          fifo_full3, fifo_write_en3;
  logic [DW-1:0] fifo_data_in3;
  logic          grant_active3;
  logic [1:0]    grant_id3;
  logic [2:0]    beat_cnt3;

  fifo_rr_arbiter #(.NUM_REQ(3), .DATA_W(DW), .MAX_BURST(MB)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid3), .req_last(req_last3), .req_data(req_data3),
    .req_ready(req_ready3), .fifo_full(fifo_full3),
    .fifo_write_en(fifo_write_en3), .fifo_data_in(fifo_data_in3),
    .grant_active(grant_active3), .grant_id(grant_id3), .beat_cnt(beat_cnt3)
  );

  // ---------------- behavioural FIFO (occupancy only) ----------------
  int   fifo_count = 0;
  logic read_en;
  assign fifo_full = (fifo_count == FIFO_DEPTH);

  always @(posedge clk) begin
    fifo_count <= fifo_count
                + ((fifo_write_en && fifo_count < FIFO_DEPTH) ? 1 : 0)
                - ((read_en && fifo_count > 0) ? 1 : 0);
  end

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];   // {grant_id, data}
  logic [9:0] exp3_q[$];
  logic [9:0] p4_q[4][$]; // {gap, last, data}
  logic [9:0] p3_q[3][$];
  localparam logic [9:0] GAP = 10'h200;

  bit spacing_en = 1'b0;
  bit have_prev  = 1'b0;
  int prev_cyc   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [9:0] beat(input logic last, input logic [7:0] data);
    return {1'b0, last, data};
  endfunction

  function automatic int pend4();
    int s = 0;
    for (int k = 0; k < 4; k++) s += p4_q[k].size();
    return s;
  endfunction

  function automatic int pend3();
    int s = 0;
    for (int k = 0; k < 3; k++) s += p3_q[k].size();
    return s;
  endfunction

  // ---------------- producer drivers ----------------
  initial begin : drivers
    logic [3:0] acc4;
    logic [2:0] acc3;
    logic [9:0] item;
    req_valid = '0; req_last = '0; req_data = '0;
    req_valid3 = '0; req_last3 = '0; req_data3 = '0;
    forever begin
      @(negedge clk);
      acc4 = req_valid & req_ready;
      acc3 = req_valid3 & req_ready3;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (p4_q[k].size() > 0) begin
          item = p4_q[k][0];
          if (item[9] || acc4[k]) void'(p4_q[k].pop_front());
        end
        if (p4_q[k].size() > 0) begin
          item = p4_q[k][0];
          req_valid[k] = !item[9];
          req_last[k]  = item[8];
          req_data[k*DW +: DW] = item[7:0];
        end else begin
          req_valid[k] = 1'b0;
          req_last[k]  = 1'b0;
          req_data[k*DW +: DW] = '0;
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (p3_q[k].size() > 0) begin
          item = p3_q[k][0];
          if (item[9] || acc3[k]) void'(p3_q[k].pop_front());
        end
        if (p3_q[k].size() > 0) begin
          item = p3_q[k][0];
          req_valid3[k] = !item[9];
          req_last3[k]  = item[8];
          req_data3[k*DW +: DW] = item[7:0];
        end else begin
          req_valid3[k] = 1'b0;
          req_last3[k]  = 1'b0;
          req_data3[k*DW +: DW] = '0;
        end
      end
    end
  end

  // ---------------- monitors ----------------
  initial begin : monitor4
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (fifo_full) check("no_write_when_full", fifo_write_en, 0);
      if (fifo_write_en) begin
        check("beat_cnt_below_cap", beat_cnt < 3'(MB), 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got id %0d data 0x%0h, expected no write", grant_id, fifo_data_in);
        end else begin
          e = exp_q.pop_front();
          check("write_id", grant_id, e[9:8]);
          check("write_data", fifo_data_in, e[7:0]);
        end
        if (spacing_en) begin
          if (have_prev) check("beat_spacing", cyc - prev_cyc, 2);
          prev_cyc  = cyc;
          have_prev = 1'b1;
        end
      end
    end
  end

  initial begin : monitor3
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (fifo_write_en3) begin
        if (exp3_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write3: got id %0d data 0x%0h, expected no write", grant_id3, fifo_data_in3);
        end else begin
          e = exp3_q.pop_front();
          check("write3_id", grant_id3, e[9:8]);
          check("write3_data", fifo_data_in3, e[7:0]);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || pend4() != 0 || grant_active) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check({name, "_exp_left"}, exp_q.size(), 0);
    check({name, "_stim_left"}, pend4(), 0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int n;
    rst        = 1'b1;
    read_en    = 1'b1;
    fifo_full3 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_req_ready", req_ready, 0);
    check("rst_write_en", fifo_write_en, 0);
    check("rst_data_in", fifo_data_in, 0);
    check("rst_grant_active", grant_active, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_grant_active3", grant_active3, 0);
    rst = 1'b0;

    // Rotation: single-beat bursts, all four valid
    spacing_en = 1'b1;
    have_prev  = 1'b0;
    p4_q[0].push_back(beat(1, 8'hA0));
    p4_q[0].push_back(beat(1, 8'hA4));
    p4_q[1].push_back(beat(1, 8'hA1));
    p4_q[2].push_back(beat(1, 8'hA2));
    p4_q[3].push_back(beat(1, 8'hA3));
    exp_q.push_back({2'd0, 8'hA0});
    exp_q.push_back({2'd1, 8'hA1});
    exp_q.push_back({2'd2, 8'hA2});
    exp_q.push_back({2'd3, 8'hA3});
    exp_q.push_back({2'd0, 8'hA4});
    wait_drain("rotation");
    spacing_en = 1'b0;

    // Burst cap: producer 1 streams ten beats without last, producer 2 cuts in
    for (int i = 0; i < 10; i++) p4_q[1].push_back(beat(0, 8'(8'h10 + i)));
    p4_q[2].push_back(beat(0, 8'h20));
    p4_q[2].push_back(beat(1, 8'h21));
    for (int i = 0; i < 4; i++) exp_q.push_back({2'd1, 8'(8'h10 + i)});
    exp_q.push_back({2'd2, 8'h20});
    exp_q.push_back({2'd2, 8'h21});
    for (int i = 4; i < 8; i++) exp_q.push_back({2'd1, 8'(8'h10 + i)});
    exp_q.push_back({2'd1, 8'h18});
    exp_q.push_back({2'd1, 8'h19});
    wait_drain("burst_cap");

    // Gap release: producer 3 drops valid for one cycle, producer 0 waits
    p4_q[3].push_back(beat(0, 8'h30));
    p4_q[3].push_back(GAP);
    p4_q[3].push_back(beat(1, 8'h31));
    p4_q[0].push_back(beat(1, 8'h40));
    exp_q.push_back({2'd3, 8'h30});
    exp_q.push_back({2'd0, 8'h40});
    exp_q.push_back({2'd3, 8'h31});
    wait_drain("gap_release");

    // Full backpressure: stop reading, fill 16 entries, grant must hold
    read_en = 1'b0;
    for (int i = 0; i < 18; i++) begin
      p4_q[0].push_back(beat(i == 17, 8'(8'h50 + i)));
      exp_q.push_back({2'd0, 8'(8'h50 + i)});
    end
    n = 0;
    while (!(fifo_full && grant_active) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("full_reached", fifo_full && grant_active, 1);
    check("full_exp_left", exp_q.size(), 2);
    for (int i = 0; i < 5; i++) begin
      check("full_req_ready", req_ready, 0);
      check("full_write_en", fifo_write_en, 0);
      check("full_grant_held", grant_active, 1);
      check("full_grant_id", grant_id, 0);
      @(negedge clk);
    end
    read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    repeat (2) @(negedge clk);
    check("full_one_freed", exp_q.size(), 1);
    check("full_held_again", grant_active && fifo_full, 1);
    read_en = 1'b1;
    wait_drain("full_backpressure");
    n = 0;
    while (fifo_count != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("fifo_drained", fifo_count, 0);

    // Reset mid-burst: grantee 2 with beat_cnt = 2
    for (int i = 0; i < 4; i++) p4_q[2].push_back(beat(0, 8'(8'h70 + i)));
    exp_q.push_back({2'd2, 8'h70});
    exp_q.push_back({2'd2, 8'h71});
    n = 0;
    while (!(grant_active && grant_id == 2'd2 && beat_cnt == 3'd1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_burst_reached", grant_active && grant_id == 2'd2 && beat_cnt == 3'd1, 1);
    @(posedge clk);
    #2;
    check("pre_rst_beat_cnt", beat_cnt, 2);
    check("pre_rst_write_en", fifo_write_en, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_write_en", fifo_write_en, 0);
    check("mid_rst_data_in", fifo_data_in, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_grant_active", grant_active, 0);
    check("mid_rst_grant_id", grant_id, 0);
    check("mid_rst_beat_cnt", beat_cnt, 0);
    @(negedge clk);
    p4_q[0].push_back(beat(1, 8'h80));
    p4_q[1].push_back(beat(1, 8'h81));
    p4_q[3].push_back(beat(1, 8'h83));
    exp_q.push_back({2'd0, 8'h80});
    exp_q.push_back({2'd1, 8'h81});
    exp_q.push_back({2'd2, 8'h72});
    exp_q.push_back({2'd2, 8'h73});
    exp_q.push_back({2'd3, 8'h83});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_drain("post_reset");

    // Non-power-of-2: three producers, only 0 and 2 active
    p3_q[0].push_back(beat(1, 8'hC0));
    p3_q[0].push_back(beat(1, 8'hC1));
    p3_q[2].push_back(beat(1, 8'hC2));
    p3_q[2].push_back(beat(1, 8'hC3));
    exp3_q.push_back({2'd0, 8'hC0});
    exp3_q.push_back({2'd2, 8'hC2});
    exp3_q.push_back({2'd0, 8'hC1});
    exp3_q.push_back({2'd2, 8'hC3});
    n = 0;
    while ((exp3_q.size() != 0 || pend3() != 0 || grant_active3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("np2_exp_left", exp3_q.size(), 0);
    check("np2_stim_left", pend3(), 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
